// File: rtl/shift_subtract_divider_if.sv
// Handshake and operand/result bundle for the shift-subtract divider.
// The master drives start and operands; the slave (divider) returns results and status.
interface shift_subtract_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/shift_subtract_divider.sv
// Unsigned restoring divider that retires one quotient bit per CALC cycle.
// A zero divisor bypasses iteration and reports all-ones quotient and remainder = dividend.
module shift_subtract_divider #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  shift_subtract_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] quotient, remainder;
  logic             dbz;

  // One extra guard bit on the trial subtract keeps the sign unambiguous.
  logic [WIDTH+1:0] r_sh, diff;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] q_nxt;

  always_comb begin
    r_sh  = {r, q[WIDTH-1]};
    diff  = r_sh - {2'b00, dsr};
    r_nxt = diff[WIDTH+1] ? r_sh[WIDTH:0] : diff[WIDTH:0];
    q_nxt = {q[WIDTH-2:0], ~diff[WIDTH+1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = (bus.divisor == '0) ? DONE : CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC:    if (cnt == LAST) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      r         <= '0;
      q         <= '0;
      dsr       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      r   <= '0;
      q   <= bus.dividend;
      dsr <= bus.divisor;
      if (bus.divisor == '0) begin
        quotient  <= '1;
        remainder <= bus.dividend;
        dbz       <= 1'b1;
      end
    end else if (state == CALC) begin
      r   <= r_nxt;
      q   <= q_nxt;
      cnt <= cnt + 1'b1;
      // Results publish together with the final iteration, on entry to DONE.
      if (cnt == LAST) begin
        quotient  <= q_nxt;
        remainder <= r_nxt[WIDTH-1:0];
        dbz       <= 1'b0;
      end
    end
  end

  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.div_by_zero = dbz;
  assign bus.busy        = (state == CALC);
  assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_shift_subtract_divider.sv
// Vector table plus hand-written corner sequences for the shift-subtract divider.
// Expected results queue when start is driven and are retired by the done monitor.
module tb_shift_subtract_divider;
  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  vec_t sb[$];

  shift_subtract_divider_if #(.WIDTH(32)) bus ();

  shift_subtract_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [31:0] dvd, input logic [31:0] dvs);
    vec_t v;
    v.dvd = dvd;
    v.dvs = dvs;
    if (dvs == 0) begin
      v.q = 32'hFFFF_FFFF; v.r = dvd; v.dbz = 1'b1;
    end else begin
      v.q = dvd / dvs; v.r = dvd % dvs; v.dbz = 1'b0;
    end
    return v;
  endfunction

  // Scoreboard: every done pulse must retire exactly one expectation.
  always @(negedge clk) begin
    if (reset && bus.done) begin
      vec_t e;
      chk("busy_with_done", {31'b0, bus.busy}, 32'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
      end else begin
        e = sb.pop_front();
        chk("quotient", bus.quotient, e.q);
        chk("remainder", bus.remainder, e.r);
        chk("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, e.dbz});
      end
    end
  end

  // Counts negedges after the acceptance edge until done; also counts busy cycles.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    @(negedge clk);
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done", lat);
    end
  endtask

  // Drive a one-cycle start, then scramble operands to prove they were captured.
  task automatic launch(input vec_t v);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = v.dvd;
    bus.divisor  = v.dvs;
    sb.push_back(v);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  vec_t tbl[9];

  initial begin
    int lat, busy_n, ndone;
    vec_t v;

    tbl[0] = '{32'd100,        32'd7,          32'd14,         32'd2,   1'b0};
    tbl[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,   1'b0};
    tbl[2] = '{32'd7,          32'd9,          32'd0,          32'd7,   1'b0};
    tbl[3] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,   1'b1};
    tbl[4] = '{32'd0,          32'd13,         32'd0,          32'd0,   1'b0};
    tbl[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,   1'b0};
    tbl[6] = '{32'd12345678,   32'd1000,       32'd12345,      32'd678, 1'b0};
    tbl[7] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,   1'b1};
    tbl[8] = '{32'h8000_0000,  32'd3,          32'd715827882,  32'd2,   1'b0};

    reset = 1'b0;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    #3;
    chk("rst_quotient", bus.quotient, 32'd0);
    chk("rst_remainder", bus.remainder, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      launch(tbl[i]);
      wait_done(lat, busy_n);
      chk($sformatf("latency_%0d", i), lat, (tbl[i].dvs == 0) ? 32'd0 : 32'd32);
      chk($sformatf("busy_cycles_%0d", i), busy_n, (tbl[i].dvs == 0) ? 32'd0 : 32'd32);
    end

    for (int i = 0; i < 6; i++) begin
      v = model($urandom, (i == 5) ? 32'd1 + ($urandom & 32'hFF) : $urandom >> (i * 5));
      launch(v);
      wait_done(lat, busy_n);
    end

    // start during CALC must be ignored and mid-run operand changes have no effect.
    launch(model(32'd1000, 32'd10));
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.dividend = 32'd77; bus.divisor = 32'd5;
    lat = 0;
    while (!bus.done && lat < 100) begin @(negedge clk); lat++; end
    @(negedge clk);
    ndone = 0;
    repeat (40) begin @(negedge clk); if (bus.done) ndone++; end
    chk("ignored_start_dones", ndone, 32'd0);

    // Reset mid-CALC abandons the run immediately.
    launch(model(32'd1000, 32'd10));
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_quotient", bus.quotient, 32'd0);
    chk("midrst_remainder", bus.remainder, 32'd0);
    chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst_done", {31'b0, bus.done}, 32'd0);
    chk("midrst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
    sb.delete();
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("inrst_busy", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle_busy", {31'b0, bus.busy}, 32'd0);
    launch(model(32'd50, 32'd8));
    wait_done(lat, busy_n);
    chk("post_rst_latency", lat, 32'd32);

    // Back-to-back: start held high; the DONE cycle accepts the new operands.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
    sb.push_back(model(32'd100, 32'd7));
    @(posedge clk);
    #1;
    bus.dividend = 32'd81; bus.divisor = 32'd9;
    sb.push_back('{32'd81, 32'd9, 32'd9, 32'd0, 1'b0});
    lat = 0;
    @(negedge clk);
    while (!bus.done && lat < 100) begin @(negedge clk); lat++; end
    chk("b2b_first_latency", lat, 32'd32);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat, busy_n);
    chk("b2b_second_latency", lat, 32'd32);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shift_subtract_divider.md
SHIFT_SUBTRACT_DIVIDER -- requirements
Module: shift_subtract_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; all widths below are for WIDTH=32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 resets the block).
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only in IDLE or DONE.
REQ-005 SHALL have port dividend  input  32  unsigned dividend; captured on the accepted start.
REQ-006 SHALL have port divisor  input  32  unsigned divisor; captured on the accepted start.
REQ-007 SHALL have port quotient  output  32  registered quotient.
REQ-008 SHALL have port remainder  output  32  registered remainder.
REQ-009 SHALL have port busy  output  1  high while an iteration is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-011 SHALL have port div_by_zero  output  1  flag set with done when the captured divisor was 0.

Function
REQ-012 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-013 IDLE/DONE + start=1: SHALL capture operands, clear the iteration counter and go to CALC; a zero divisor instead goes directly to DONE.
REQ-014 SHALL hold the work register {R[32:0], Q[31:0]}: R=0 and Q=dividend on capture.
REQ-015 Each CALC cycle SHALL shift {R,Q} left by one, trial-subtract D = R_shifted - {1'b0,divisor} in 33 bits, and if D is non-negative set R=D, Q[0]=1; otherwise restore R and set Q[0]=0.
REQ-016 SHALL run exactly 32 CALC cycles, tracked by a 6-bit counter, then enter DONE.
REQ-017 Latency: start accepted at edge 0 -> done=1 and quotient/remainder valid in the cycle after edge 32 (33rd cycle); divide-by-zero -> done in the cycle after edge 0.
REQ-018 done SHALL be high for exactly one cycle per accepted start; busy SHALL be high in CALC only, never together with done.
REQ-019 quotient/remainder SHALL update only on entry to DONE and SHALL hold their values until the next result or reset.
REQ-020 Divide-by-zero SHALL give quotient=32'hFFFFFFFF, remainder=dividend and div_by_zero=1; otherwise div_by_zero=0 on entry to DONE.
REQ-021 div_by_zero SHALL hold its value with quotient/remainder until the next result.
REQ-022 start while in CALC SHALL be ignored; the operation in progress and its operands are unaffected.
REQ-023 DONE + start=1 SHALL accept the new operation in that cycle (back-to-back); DONE + start=0 SHALL return to IDLE.
REQ-024 Operand input changes after capture SHALL NOT affect the result.
REQ-025 Results SHALL satisfy dividend = quotient*divisor + remainder, remainder < divisor, for all nonzero divisors, including dividend < divisor (quotient 0) and dividend = 0.

Reset
REQ-026 reset=0 SHALL immediately, without a clock, force state=IDLE, counter=0, work register=0, quotient=0, remainder=0, busy=0, done=0 and div_by_zero=0.
REQ-027 Reset asserted mid-CALC SHALL abandon the operation with no done pulse; after release the block SHALL wait in IDLE for a new start.
REQ-028 start SHALL be ignored while reset=0 and in the first edge it is sampled after release only if in IDLE (normal acceptance).

Verification
REQ-029 dividend=100, divisor=7, start one cycle -> busy for 32 cycles, then done pulse with quotient=14, remainder=2, div_by_zero=0.
REQ-030 dividend=32'hFFFFFFFF, divisor=1 -> quotient=32'hFFFFFFFF, remainder=0; then dividend=7, divisor=9 -> quotient=0, remainder=7.
REQ-031 dividend=5, divisor=0 -> done in the cycle after the start edge, busy never high, quotient=32'hFFFFFFFF, remainder=5, div_by_zero=1.
REQ-032 start 1000/10, pulse start with 9/3 at CALC cycle 5, change operands mid-run -> single done with quotient=100, remainder=0.
REQ-033 start 1000/10, reset=0 at CALC cycle 10 -> all outputs 0 at once, no done; after release 50/8 -> quotient=6, remainder=2.
REQ-034 start held high through done with new operands 81/9 -> second run accepted in the DONE cycle, done 33 cycles later with quotient=9, remainder=0.
